// File: rtl/ldpc_pkg.sv
// Shared definitions for the LDPC check-node datapath: default widths,
// the check-node FSM state type and the saturating magnitude helper.
package ldpc_pkg;

  localparam int CNU_QUAN_WIDTH = 6;
  localparam int CNU_MAX_DEG    = 8;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    EMIT    = 2'd2
  } cnu_state_e;

  // |v| for a w-bit two's-complement value carried sign-extended in 32 bits;
  // the most negative code folds onto the largest positive magnitude.
  function automatic logic [31:0] sat_abs(input logic signed [31:0] v, input int w);
    logic signed [31:0] most_neg;
    most_neg = -(32'sd1 <<< (w - 1));
    if (v == most_neg) begin
      sat_abs = (32'd1 << (w - 1)) - 32'd1;
    end else if (v < 0) begin
      sat_abs = -v;
    end else begin
      sat_abs = v;
    end
  endfunction

endpackage

// File: rtl/minsum_tracker.sv
// Running min1/min2/argmin/sign-parity over the magnitudes of one check node.
// clr restarts the search; upd folds in beat number idx.
module minsum_tracker #(
  parameter int MW = 5,
  parameter int IW = 3
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          upd,
  input  logic [MW-1:0] mag,
  input  logic          sign,
  input  logic [IW-1:0] idx,
  output logic [MW-1:0] min1,
  output logic [MW-1:0] min2,
  output logic [IW-1:0] idx1,
  output logic          parity
);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      min1   <= '1;
      min2   <= '1;
      idx1   <= '0;
      parity <= 1'b0;
    end else if (upd) begin
      parity <= parity ^ sign;
      // Strict compares: on a tie the earlier index keeps min1 and the
      // newcomer lands in min2.
      if (mag < min1) begin
        min2 <= min1;
        min1 <= mag;
        idx1 <= idx;
      end else if (mag < min2) begin
        min2 <= mag;
      end
    end
  end

endmodule

// File: rtl/cnu_serial_minsum.sv
// Serial offset-min-sum check-node unit: gathers deg V2C messages, then
// returns deg C2V messages one per accepted handshake.
module cnu_serial_minsum
  import ldpc_pkg::*;
#(
  parameter int  quan_width = CNU_QUAN_WIDTH,
  parameter int  MAX_DEG    = CNU_MAX_DEG,
  parameter int  OFFSET     = 0,
  localparam int DW         = $clog2(MAX_DEG + 1),
  localparam int IW         = $clog2(MAX_DEG),
  localparam int MW         = quan_width - 1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  input  logic [DW-1:0]                deg,
  input  logic                         v2c_valid,
  input  logic signed [quan_width-1:0] v2c_in,
  output logic                         v2c_ready,
  output logic                         c2v_valid,
  input  logic                         c2v_ready,
  output logic signed [quan_width-1:0] c2v_out,
  output logic [IW-1:0]                c2v_idx,
  output logic                         busy,
  output logic                         done,
  output logic                         err,
  output cnu_state_e                   dbg_state
);

  localparam logic [MW-1:0] OFF_M = MW'(OFFSET);

  // Handshakes: a beat transfers on a cycle where valid && ready are both
  // high at the rising edge. v2c_ready depends only on state; c2v_valid is
  // held with stable data/index until c2v_ready takes it.

  cnu_state_e          state_q, state_d;
  logic [DW-1:0]       deg_q;
  logic [IW-1:0]       k_q;
  logic [MAX_DEG-1:0]  sign_q;
  logic                done_q, err_q;

  logic                deg_ok, start_ok, v2c_fire, c2v_fire, last_k;
  logic [MW-1:0]       mag_in, min1, min2, m_sel, mag_out;
  logic [IW-1:0]       idx1;
  logic                parity, s_out;

  assign deg_ok   = (deg >= DW'(2)) && (deg <= DW'(MAX_DEG));
  assign start_ok = (state_q == IDLE) && start && deg_ok;
  assign v2c_fire = (state_q == COLLECT) && v2c_valid;
  assign c2v_fire = (state_q == EMIT) && c2v_ready;
  assign last_k   = (DW'(k_q) == (deg_q - DW'(1)));
  assign mag_in   = MW'(sat_abs(32'(v2c_in), quan_width));

  minsum_tracker #(
    .MW(MW),
    .IW(IW)
  ) u_tracker (
    .clk   (clk),
    .rst   (rst),
    .clr   (start_ok),
    .upd   (v2c_fire),
    .mag   (mag_in),
    .sign  (v2c_in[quan_width-1]),
    .idx   (k_q),
    .min1  (min1),
    .min2  (min2),
    .idx1  (idx1),
    .parity(parity)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start_ok) state_d = COLLECT;
      COLLECT: if (v2c_fire && last_k) state_d = EMIT;
      EMIT:    if (c2v_fire && last_k) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      deg_q   <= '0;
      k_q     <= '0;
      sign_q  <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start && deg_ok) begin
            deg_q  <= deg;
            k_q    <= '0;
            sign_q <= '0;
          end else if (start) begin
            err_q <= 1'b1;
          end
        end
        COLLECT: begin
          if (v2c_fire) begin
            sign_q[k_q] <= v2c_in[quan_width-1];
            k_q         <= last_k ? '0 : k_q + IW'(1);
          end
        end
        EMIT: begin
          if (c2v_fire) begin
            k_q    <= last_k ? '0 : k_q + IW'(1);
            done_q <= last_k;
          end
        end
        default: k_q <= '0;
      endcase
    end
  end

  // Own edge excluded: the argmin edge sees min2, every other edge min1.
  assign m_sel   = (k_q == idx1) ? min2 : min1;
  assign mag_out = (m_sel > OFF_M) ? (m_sel - OFF_M) : '0;
  assign s_out   = parity ^ sign_q[k_q];

  always_comb begin
    c2v_out = '0;
    c2v_idx = '0;
    if (state_q == EMIT) begin
      c2v_out = s_out ? -$signed({1'b0, mag_out}) : $signed({1'b0, mag_out});
      c2v_idx = k_q;
    end
  end

  assign v2c_ready = (state_q == COLLECT);
  assign c2v_valid = (state_q == EMIT);
  assign busy      = (state_q != IDLE);
  assign done      = done_q;
  assign err       = err_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_cnu_serial_minsum.sv
// Directed and randomized bench for cnu_serial_minsum: two instances (OFFSET
// 0 and 1) share stimulus and are compared against an exclude-self reference.
module tb_cnu_serial_minsum;
  import ldpc_pkg::*;

  localparam int QW = 6;
  localparam int MD = 8;
  localparam int DW = $clog2(MD + 1);
  localparam int IW = $clog2(MD);

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic                 start, v2c_valid, c2v_ready;
  logic [DW-1:0]        deg;
  logic signed [QW-1:0] v2c_in;

  logic                 v2c_ready0, c2v_valid0, busy0, done0, err0;
  logic                 v2c_ready1, c2v_valid1, busy1, done1, err1;
  logic signed [QW-1:0] c2v_out0, c2v_out1;
  logic [IW-1:0]        c2v_idx0, c2v_idx1;
  cnu_state_e           st0, st1;

  cnu_serial_minsum #(.quan_width(QW), .MAX_DEG(MD), .OFFSET(0)) dut0 (
    .clk(clk), .rst(rst), .start(start), .deg(deg),
    .v2c_valid(v2c_valid), .v2c_in(v2c_in), .v2c_ready(v2c_ready0),
    .c2v_valid(c2v_valid0), .c2v_ready(c2v_ready), .c2v_out(c2v_out0),
    .c2v_idx(c2v_idx0), .busy(busy0), .done(done0), .err(err0), .dbg_state(st0)
  );

  cnu_serial_minsum #(.quan_width(QW), .MAX_DEG(MD), .OFFSET(1)) dut1 (
    .clk(clk), .rst(rst), .start(start), .deg(deg),
    .v2c_valid(v2c_valid), .v2c_in(v2c_in), .v2c_ready(v2c_ready1),
    .c2v_valid(c2v_valid1), .c2v_ready(c2v_ready), .c2v_out(c2v_out1),
    .c2v_idx(c2v_idx1), .busy(busy1), .done(done1), .err(err1), .dbg_state(st1)
  );

  // ---------------- scoreboard ----------------
  int checks   = 0;
  int failures = 0;
  int vals[MD];
  logic signed [31:0] exp_q0[$];
  logic signed [31:0] exp_q1[$];

  task automatic check(input string tag, input logic signed [31:0] obs,
                       input logic signed [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Reference: C2V for edge k is the min saturated magnitude and the sign
  // product over every other edge, less the offset clamped at zero.
  function automatic int ref_c2v(input int d, input int k, input int off);
    int best;
    int a;
    bit s;
    best = 1 << 30;
    s    = 1'b0;
    for (int j = 0; j < d; j++) begin
      if (j != k) begin
        if (vals[j] == -(1 << (QW - 1))) a = (1 << (QW - 1)) - 1;
        else if (vals[j] < 0)            a = -vals[j];
        else                             a = vals[j];
        s ^= (vals[j] < 0);
        if (a < best) best = a;
      end
    end
    best = best - off;
    if (best < 0) best = 0;
    return s ? -best : best;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // gap_mode: 0 none, 1 two idle cycles before beat 1, 2 random 0..2
  task automatic run_node(input int d, input int gap_mode, input int stall0,
                          input bit rnd_ready, input bit poke_start);
    int gaps, emitted, cyc, stalls;
    bit r;
    exp_q0.delete();
    exp_q1.delete();
    for (int k = 0; k < d; k++) begin
      exp_q0.push_back(ref_c2v(d, k, 0));
      exp_q1.push_back(ref_c2v(d, k, 1));
    end
    deg   = DW'(d);
    start = 1'b1;
    tick();
    start = 1'b0;
    check("busy_after_start", busy0, 1);
    check("v2c_ready0_collect", v2c_ready0, 1);
    check("v2c_ready1_collect", v2c_ready1, 1);
    for (int i = 0; i < d; i++) begin
      gaps = (gap_mode == 1) ? ((i == 1) ? 2 : 0) :
             (gap_mode == 2) ? int'($urandom_range(0, 2)) : 0;
      repeat (gaps) begin
        v2c_valid = 1'b0;
        v2c_in    = QW'($urandom);
        tick();
      end
      v2c_valid = 1'b1;
      v2c_in    = QW'(vals[i]);
      if (poke_start && i == 1) begin
        start = 1'b1;
        deg   = DW'(3);
      end
      tick();
      start = 1'b0;
      if (poke_start && i == 1) begin
        check("err_on_busy_start", err0, 0);
        check("busy_after_poke", busy0, 1);
      end
    end
    v2c_valid = 1'b0;
    check("first_valid_latency0", c2v_valid0, 1);
    check("first_valid_latency1", c2v_valid1, 1);
    emitted = 0;
    cyc     = 0;
    stalls  = stall0;
    while (emitted < d && cyc < 200) begin
      check("c2v_valid0", c2v_valid0, 1);
      check("c2v_valid1", c2v_valid1, 1);
      check("c2v_out0", c2v_out0, exp_q0[0]);
      check("c2v_out1", c2v_out1, exp_q1[0]);
      check("c2v_idx0", c2v_idx0, emitted);
      check("c2v_idx1", c2v_idx1, emitted);
      check("done_early", done0, 0);
      if (stalls > 0) begin
        r = 1'b0;
        stalls--;
      end else if (rnd_ready) begin
        r = ($urandom_range(0, 3) != 0);
      end else begin
        r = 1'b1;
      end
      c2v_ready = r;
      tick();
      cyc++;
      if (r) begin
        void'(exp_q0.pop_front());
        void'(exp_q1.pop_front());
        emitted++;
      end
    end
    c2v_ready = 1'b0;
    check("emit_budget", emitted, d);
    check("done_pulse0", done0, 1);
    check("done_pulse1", done1, 1);
    check("busy_after_done", busy0, 0);
    check("valid_after_done", c2v_valid0, 0);
    tick();
    check("done_clear", done0, 0);
  endtask

  task automatic bad_start(input int d);
    deg   = DW'(d);
    start = 1'b1;
    tick();
    start = 1'b0;
    check("err_pulse", err0, 1);
    check("err_busy", busy0, 0);
    check("err_v2c_ready", v2c_ready0, 0);
    tick();
    check("err_clear", err0, 0);
    check("err_still_idle", busy0, 0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst       = 1'b1;
    start     = 1'b0;
    deg       = '0;
    v2c_valid = 1'b0;
    v2c_in    = '0;
    c2v_ready = 1'b0;
    tick();
    tick();
    check("rst_busy", busy0, 0);
    check("rst_v2c_ready", v2c_ready0, 0);
    check("rst_c2v_valid", c2v_valid0, 0);
    check("rst_c2v_out", c2v_out0, 0);
    check("rst_c2v_idx", c2v_idx0, 0);
    check("rst_done", done0, 0);
    check("rst_err", err0, 0);
    rst = 1'b0;
    tick();

    vals[0] = 5;   vals[1] = -2;  vals[2] = 7;
    run_node(3, 0, 0, 1'b0, 1'b0);

    vals[0] = -32; vals[1] = 3;   vals[2] = 3;  vals[3] = -10;
    run_node(4, 0, 0, 1'b0, 1'b0);

    vals[0] = 4;   vals[1] = -6;
    run_node(2, 0, 3, 1'b0, 1'b0);

    vals[0] = 1;   vals[1] = 0;   vals[2] = -1;
    run_node(3, 1, 0, 1'b0, 1'b1);

    bad_start(1);
    bad_start(9);

    // Reset partway through collection.
    deg   = DW'(4);
    start = 1'b1;
    tick();
    start     = 1'b0;
    v2c_valid = 1'b1;
    v2c_in    = QW'(9);
    tick();
    v2c_in = QW'(-4);
    tick();
    rst = 1'b1;
    tick();
    check("midrst_busy", busy0, 0);
    check("midrst_c2v_valid", c2v_valid0, 0);
    check("midrst_done", done0, 0);
    rst       = 1'b0;
    v2c_valid = 1'b0;
    tick();
    check("midrst_no_done", done0, 0);
    check("midrst_idle", busy0, 0);
    vals[0] = 9;   vals[1] = -3;
    run_node(2, 0, 0, 1'b0, 1'b0);

    repeat (25) begin
      int d;
      d = int'($urandom_range(2, MD));
      for (int j = 0; j < MD; j++) begin
        if ($urandom_range(0, 1) == 1) vals[j] = int'($urandom_range(0, 63)) - 32;
        else                           vals[j] = int'($urandom_range(0, 6)) - 3;
      end
      run_node(d, 2, 0, 1'b1, 1'b0);
    end

    // ---------------- final report ----------------
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
